lsu_access_ctrl: RTL

- Load/store access controller directly upstream of data_memory, in the MEM stage.
- Accepts one load/store request per transaction from the execute stage over a valid/ready handshake.
- Aligned accesses are issued to data_memory as a single beat. Misaligned halfword/word accesses are split into byte beats.
- Load results are reassembled and sign-/zero-extended, then returned as a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_access_ctrl_if.sv | 38 +++
 rtl/lsu_load_extend.sv | 23 ++
 rtl/lsu_access_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store access controller:
// funct3 size codes, data_memory dm_ctrl codes, FSM states and size decoding.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] DM_LB   = 3'b000;
   localparam logic [2:0] DM_LH   = 3'b001;
   localparam logic [2:0] DM_LW   = 3'b010;
   localparam logic [2:0] DM_LBU  = 3'b100;
   localparam logic [2:0] DM_LHU  = 3'b101;
   localparam logic [2:0] DM_IDLE = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   // Access size in bytes; 0 marks a code with no defined size.
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      logic [2:0] n;
      case (funct3[1:0])
         2'b00:   n = 3'd1;
         2'b01:   n = 3'd2;
         2'b10:   n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_access_ctrl_if.sv
// Execute-stage request/response and data_memory bus for lsu_access_ctrl.
// Request handshake: a transfer happens on a rising edge where req_valid and req_ready are both 1;
// rsp_valid is a single-cycle pulse with no backpressure.
interface lsu_access_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [2:0]       req_funct3;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [TAG_W-1:0] req_tag;

   logic             rsp_valid;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic [TAG_W-1:0] rsp_tag;

   logic [31:0]      mem_address;
   logic [31:0]      mem_write_data;
   logic             mem_write_enable;
   logic [2:0]       mem_dm_ctrl;
   logic [31:0]      mem_read_data;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag, mem_read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tag,
             mem_address, mem_write_data, mem_write_enable, mem_dm_ctrl
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag, mem_read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tag,
             mem_address, mem_write_data, mem_write_enable, mem_dm_ctrl
   );

endinterface

// File: rtl/lsu_load_extend.sv
// Load result formatting: picks the low byte/half/word from the 4-byte lane buffer
// and sign- or zero-extends according to funct3.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] lanes,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   always_comb begin
      rdata = '0;
      case (funct3)
         F3_B:    rdata = {{24{lanes[7]}}, lanes[7:0]};
         F3_H:    rdata = {{16{lanes[15]}}, lanes[15:0]};
         F3_W:    rdata = lanes;
         F3_BU:   rdata = {24'd0, lanes[7:0]};
         F3_HU:   rdata = {16'd0, lanes[15:0]};
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/lsu_access_ctrl.sv
// MEM-stage load/store controller in front of data_memory; splits misaligned accesses into byte beats.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with an error response instead of splitting.
module lsu_access_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 256,
   parameter int TAG_W     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_access_ctrl_if.slave  bus,
   output lsu_state_t        dbg_state
);

   lsu_state_t       state, state_d;
   logic [1:0]       beat;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [TAG_W-1:0] tag_q;
   logic             err_q;
   logic             mis_q;
   logic [3:0][7:0]  lanes;

   logic [2:0]  size_in, size_q;
   logic [32:0] end_addr;
   logic        range_err, mis_in, err_in, last_beat;
   logic [3:0][7:0] wbytes;
   logic [31:0] ext_rdata;

   logic        req_ready_c, rsp_valid_c, rsp_err_c, mem_we_c;
   logic [31:0] rsp_rdata_c, mem_addr_c, mem_wdata_c;
   logic [2:0]  mem_dm_c;
   logic [TAG_W-1:0] rsp_tag_c;

   // Request classification, evaluated on the incoming request in IDLE.
   assign size_in   = access_size(bus.req_funct3);
   assign end_addr  = {1'b0, bus.req_addr} + 33'(size_in) - 33'd1;
   assign range_err = (size_in == 3'd0) || (end_addr >= 33'(MEM_BYTES));
   assign mis_in    = ((size_in == 3'd2) && bus.req_addr[0]) ||
                      ((size_in == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
   assign err_in    = !funct3_legal(bus.req_we, bus.req_funct3) || range_err || mis_in;
`else
   assign err_in    = !funct3_legal(bus.req_we, bus.req_funct3) || range_err;
`endif

   assign size_q    = access_size(f3_q);
   assign last_beat = !mis_q || ({1'b0, beat} == (size_q - 3'd1));
   assign wbytes    = wdata_q;

   lsu_load_extend u_extend (
      .lanes  (lanes),
      .funct3 (f3_q),
      .rdata  (ext_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         beat    <= 2'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         tag_q   <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         lanes   <= '0;
      end else begin
         state <= state_d;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  f3_q    <= bus.req_funct3;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  tag_q   <= bus.req_tag;
                  err_q   <= err_in;
                  mis_q   <= mis_in;
                  beat    <= 2'd0;
                  lanes   <= '0;
               end
            end
            BEAT: begin
               // data_memory reads combinationally, so the beat's data is valid by this edge.
               if (mis_q) begin
                  lanes[beat] <= bus.mem_read_data[7:0];
                  beat        <= beat + 2'd1;
               end else begin
                  lanes <= bus.mem_read_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      rsp_rdata_c = 32'd0;
      rsp_err_c   = 1'b0;
      rsp_tag_c   = '0;
      mem_we_c    = 1'b0;
      mem_addr_c  = 32'd0;
      mem_wdata_c = 32'd0;
      mem_dm_c    = DM_IDLE;
      case (state)
         IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) state_d = err_in ? RESP : BEAT;
         end
         BEAT: begin
            mem_we_c = we_q;
            if (mis_q) begin
               mem_addr_c  = addr_q + 32'(beat);
               mem_wdata_c = {24'd0, wbytes[beat]};
               mem_dm_c    = we_q ? DM_LB : DM_LBU;
            end else begin
               mem_addr_c  = addr_q;
               mem_wdata_c = wdata_q;
               if (we_q)                 mem_dm_c = f3_q;
               else if (size_q == 3'd4)  mem_dm_c = DM_LW;
               else if (size_q == 3'd2)  mem_dm_c = DM_LH;
               else                      mem_dm_c = DM_LB;
            end
            if (last_beat) state_d = RESP;
         end
         RESP: begin
            rsp_valid_c = 1'b1;
            rsp_err_c   = err_q;
            rsp_tag_c   = tag_q;
            rsp_rdata_c = (we_q || err_q) ? 32'd0 : ext_rdata;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready        = req_ready_c;
   assign bus.rsp_valid        = rsp_valid_c;
   assign bus.rsp_rdata        = rsp_rdata_c;
   assign bus.rsp_err          = rsp_err_c;
   assign bus.rsp_tag          = rsp_tag_c;
   assign bus.mem_address      = mem_addr_c;
   assign bus.mem_write_data   = mem_wdata_c;
   assign bus.mem_write_enable = mem_we_c;
   assign bus.mem_dm_ctrl      = mem_dm_c;
   assign dbg_state            = state;

endmodule
